// File: rtl/hostif_arb_pkg.sv
// Shared types and constants for the two-host Avalon-MM arbiter.
package hostif_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_H0   = 2'b01;
  localparam logic [1:0] GRANT_H1   = 2'b10;

  // Hold counter width covers MAX_HOLD up to 255
  localparam int unsigned HOLD_W = 8;

  function automatic logic [1:0] grant_of(input arb_state_e st);
    case (st)
      ST_GRANT0: grant_of = GRANT_H0;
      ST_GRANT1: grant_of = GRANT_H1;
      default:   grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin tie-break: picks the next owner from the request pair.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       next_owner_c
);

  // On a tie the host not served last wins; otherwise the sole requester
  always_comb begin
    next_owner_c = req[1];
    if (req == 2'b11) begin
      next_owner_c = ~last;
    end
  end

endmodule

// File: rtl/dual_host_arbiter.sv
// Arbitrates two Avalon-MM hosts onto one shared slave port with a bounded
// hold count and no mid-transfer ownership change.
module dual_host_arbiter
  import hostif_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     h0_address,
  input  logic [DATA_W/8-1:0]   h0_byteenable,
  input  logic [DATA_W-1:0]     h0_writedata,
  input  logic                  h0_read,
  input  logic                  h0_write,
  output logic [DATA_W-1:0]     h0_readdata,
  output logic                  h0_waitrequest,
  input  logic [ADDR_W-1:0]     h1_address,
  input  logic [DATA_W/8-1:0]   h1_byteenable,
  input  logic [DATA_W-1:0]     h1_writedata,
  input  logic                  h1_read,
  input  logic                  h1_write,
  output logic [DATA_W-1:0]     h1_readdata,
  output logic                  h1_waitrequest,
  output logic [ADDR_W-1:0]     s_address,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [DATA_W-1:0]     s_writedata,
  output logic                  s_read,
  output logic                  s_write,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_waitrequest,
  output logic [1:0]            grant,
  output logic                  arb_error
);

  arb_state_e          state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_inc;
  logic                last, last_nxt;
  logic                arb_error_nxt;
  logic                req0, req1, own_req, other_req;
  logic                own_read, own_write;
  logic                owner, granted;
  logic                rr_next;

  assign req0      = h0_read | h0_write;
  assign req1      = h1_read | h1_write;
  assign owner     = (state == ST_GRANT1);
  assign granted   = (state != ST_IDLE);
  assign own_read  = owner ? h1_read  : h0_read;
  assign own_write = owner ? h1_write : h0_write;
  assign own_req   = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;

  rr_arbiter_2 u_rr (
    .req          ({req1, req0}),
    .last         (last),
    .next_owner_c (rr_next)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      last      <= 1'b1;
      grant     <= GRANT_NONE;
      arb_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      last      <= last_nxt;
      grant     <= grant_of(state_nxt);
      arb_error <= arb_error_nxt;
    end
  end

  // Next owner, hold count and last-served bookkeeping
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    last_nxt      = last;
    hold_inc      = (hold_cnt >= HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + HOLD_W'(1);
    arb_error_nxt = arb_error | (granted & own_read & own_write);
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_nxt = rr_next ? ST_GRANT1 : ST_GRANT0;
          last_nxt  = rr_next;
          hold_nxt  = '0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!own_req) begin
          hold_nxt = '0;
          if (other_req) begin
            state_nxt = owner ? ST_GRANT0 : ST_GRANT1;
            last_nxt  = ~owner;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (!s_waitrequest) begin
          if (other_req && (hold_inc == HOLD_W'(MAX_HOLD))) begin
            state_nxt = owner ? ST_GRANT0 : ST_GRANT1;
            last_nxt  = ~owner;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slave-side mux; a read+write collision is forwarded as a write only
  always_comb begin
    s_address      = owner ? h1_address    : h0_address;
    s_byteenable   = owner ? h1_byteenable : h0_byteenable;
    s_writedata    = owner ? h1_writedata  : h0_writedata;
    s_write        = granted & own_write;
    s_read         = granted & own_read & ~own_write;
    h0_waitrequest = (state == ST_GRANT0) ? s_waitrequest : 1'b1;
    h1_waitrequest = (state == ST_GRANT1) ? s_waitrequest : 1'b1;
    h0_readdata    = s_readdata;
    h1_readdata    = s_readdata;
  end

endmodule

// File: tb/tb_dual_host_arbiter.sv
// Scoreboard bench for dual_host_arbiter: MAX_HOLD=4 instance drives the slave,
// a MAX_HOLD=1 twin on the same inputs is checked for strict alternation.
module tb_dual_host_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] h0_address = '0, h1_address = '0;
  logic [3:0]  h0_byteenable = '0, h1_byteenable = '0;
  logic [31:0] h0_writedata = '0, h1_writedata = '0;
  logic        h0_read = 1'b0, h0_write = 1'b0, h1_read = 1'b0, h1_write = 1'b0;
  logic [31:0] h0_readdata, h1_readdata;
  logic        h0_waitrequest, h1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write;
  logic        s_waitrequest = 1'b0;
  logic [1:0]  grant;
  logic        arb_error;
  logic        rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr = '0;

  logic [31:0] d1_h0_readdata, d1_h1_readdata, d1_s_address, d1_s_writedata;
  logic [3:0]  d1_s_byteenable;
  logic        d1_h0_waitrequest, d1_h1_waitrequest, d1_s_read, d1_s_write, d1_arb_error;
  logic [1:0]  d1_grant;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_xfer = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: read data derived from the address unless overridden
  assign s_readdata = rd_ovr_en ? rd_ovr : (s_address ^ 32'h5A5A_5A5A);

  dual_host_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .h0_address(h0_address), .h0_byteenable(h0_byteenable), .h0_writedata(h0_writedata),
    .h0_read(h0_read), .h0_write(h0_write), .h0_readdata(h0_readdata), .h0_waitrequest(h0_waitrequest),
    .h1_address(h1_address), .h1_byteenable(h1_byteenable), .h1_writedata(h1_writedata),
    .h1_read(h1_read), .h1_write(h1_write), .h1_readdata(h1_readdata), .h1_waitrequest(h1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .arb_error(arb_error)
  );

  dual_host_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(1)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .h0_address(h0_address), .h0_byteenable(h0_byteenable), .h0_writedata(h0_writedata),
    .h0_read(h0_read), .h0_write(h0_write), .h0_readdata(d1_h0_readdata), .h0_waitrequest(d1_h0_waitrequest),
    .h1_address(h1_address), .h1_byteenable(h1_byteenable), .h1_writedata(h1_writedata),
    .h1_read(h1_read), .h1_write(h1_write), .h1_readdata(d1_h1_readdata), .h1_waitrequest(d1_h1_waitrequest),
    .s_address(d1_s_address), .s_byteenable(d1_s_byteenable), .s_writedata(d1_s_writedata),
    .s_read(d1_s_read), .s_write(d1_s_write), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(d1_grant), .arb_error(d1_arb_error)
  );

  function automatic exp_t mk(input int h, input logic [31:0] a, input logic wr, input logic [31:0] d);
    exp_t e;
    e.grant = (h == 1) ? 2'b10 : 2'b01;
    e.addr  = a;
    e.wr    = wr;
    e.data  = wr ? d : (a ^ 32'h5A5A_5A5A);
    e.be    = (h == 1) ? 4'h3 : 4'hF;
    return e;
  endfunction

  // Scoreboard: every completed slave transfer is matched against the queue head
  always @(negedge clk) begin
    if (rst_n && (s_read || s_write) && !s_waitrequest) begin
      exp_t e;
      logic [31:0] obs_data;
      logic        nonown_wait;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      n_xfer++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer_unexpected: got grant=%b addr=%h, expected no transfer", grant, s_address);
      end else begin
        n_pass++;
        e = exp_q.pop_front();
        obs_data    = s_write ? s_writedata : ((grant == 2'b10) ? h1_readdata : h0_readdata);
        nonown_wait = (grant == 2'b10) ? h0_waitrequest : h1_waitrequest;
        n_checks++;
        if ({grant, s_address, s_byteenable} !== {e.grant, e.addr, e.be})
          $display("FAIL xfer_owner: got grant=%b addr=%h be=%h, expected grant=%b addr=%h be=%h",
                   grant, s_address, s_byteenable, e.grant, e.addr, e.be);
        else n_pass++;
        n_checks++;
        if ({s_read, s_write} !== {~e.wr, e.wr})
          $display("FAIL xfer_strobes: got rd=%b wr=%b, expected rd=%b wr=%b", s_read, s_write, ~e.wr, e.wr);
        else n_pass++;
        n_checks++;
        if (obs_data !== e.data)
          $display("FAIL xfer_data: got %h expected %h (addr %h)", obs_data, e.data, e.addr);
        else n_pass++;
        n_checks++;
        if (nonown_wait !== 1'b1)
          $display("FAIL xfer_nonowner_wait: got %b expected 1", nonown_wait);
        else n_pass++;
      end
    end
  end

  task automatic drive_host(input int h, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    if (h == 0) begin
      h0_read = rd; h0_write = wr; h0_address = a; h0_writedata = d; h0_byteenable = 4'hF;
    end else begin
      h1_read = rd; h1_write = wr; h1_address = a; h1_writedata = d; h1_byteenable = 4'h3;
    end
  endtask

  // Hold a request until its waitrequest drops, then return just after that edge
  task automatic host_xfer(input int h, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input int budget);
    bit ok = 1'b0;
    drive_host(h, rd, wr, a, d);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (((h == 0) ? h0_waitrequest : h1_waitrequest) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL host%0d_timeout: got no completion in %0d cycles, expected completion", h, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_host(0, 1'b0, 1'b0, '0, '0);
    drive_host(1, 1'b0, 1'b0, '0, '0);
    s_waitrequest = 1'b0;
    rd_ovr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_host(0, 1'b0, 1'b1, 32'h10, 32'h1);
    drive_host(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({grant, s_read, s_write, h0_waitrequest, h1_waitrequest, arb_error} !== 7'b00_00_11_0)
      $display("FAIL reset_outputs: got grant=%b rd=%b wr=%b w0=%b w1=%b err=%b, expected 00 0 0 1 1 0",
               grant, s_read, s_write, h0_waitrequest, h1_waitrequest, arb_error);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({grant, s_read, s_write, h0_waitrequest, h1_waitrequest} !== 6'b00_00_11)
      $display("FAIL reset_idle: got grant=%b rd=%b wr=%b w0=%b w1=%b, expected 00 0 0 1 1",
               grant, s_read, s_write, h0_waitrequest, h1_waitrequest);
    else n_pass++;
  endtask

  task automatic test_single_write();
    int waits = 0;
    do_reset();
    exp_q.push_back(mk(0, 32'h100, 1'b1, 32'hDEAD_BEEF));
    drive_host(0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    n_checks++;
    if ({grant, h0_waitrequest, s_write} !== 4'b00_1_0)
      $display("FAIL sw_latency: got grant=%b w0=%b wr=%b, expected 00 1 0", grant, h0_waitrequest, s_write);
    else n_pass++;
    while (h0_waitrequest && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    n_checks++;
    if (waits !== 1 || grant !== 2'b01)
      $display("FAIL sw_grant_cycle: got wait=%0d grant=%b, expected wait=1 grant=01", waits, grant);
    else n_pass++;
    @(posedge clk); #1;
    drive_host(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (s_write !== 1'b0)
      $display("FAIL sw_single_pulse: got s_write=%b expected 0", s_write);
    else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    exp_q.push_back(mk(0, 32'h200, 1'b0, '0));
    exp_q.push_back(mk(1, 32'h300, 1'b0, '0));
    fork
      begin host_xfer(0, 1'b1, 1'b0, 32'h200, '0, 10); drive_host(0, 1'b0, 1'b0, '0, '0); end
      begin host_xfer(1, 1'b1, 1'b0, 32'h300, '0, 10); drive_host(1, 1'b0, 1'b0, '0, '0); end
      begin
        for (int c = 0; c < 5 && grant != 2'b01; c++) @(negedge clk);
        n_checks++;
        if (d1_grant !== 2'b01) $display("FAIL tie_hold1_first: got %b expected 01", d1_grant);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (d1_grant !== 2'b10) $display("FAIL tie_hold1_switch: got %b expected 10", d1_grant);
        else n_pass++;
      end
    join
  endtask

  task automatic test_stream();
    do_reset();
    n_xfer = 0; first_cyc = -1; last_cyc = -1;
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 4; k++) begin
        int i = (blk / 2) * 4 + k;
        if (blk % 2 == 0) exp_q.push_back(mk(0, 32'h1000 + i, 1'b1, 32'hA000_0000 + i));
        else              exp_q.push_back(mk(1, 32'h2000 + i, 1'b1, 32'hB000_0000 + i));
      end
    end
    fork
      begin
        for (int i = 0; i < 8; i++) host_xfer(0, 1'b0, 1'b1, 32'h1000 + i, 32'hA000_0000 + i, 20);
        drive_host(0, 1'b0, 1'b0, '0, '0);
      end
      begin
        for (int i = 0; i < 8; i++) host_xfer(1, 1'b0, 1'b1, 32'h2000 + i, 32'hB000_0000 + i, 20);
        drive_host(1, 1'b0, 1'b0, '0, '0);
      end
      begin
        logic [1:0] prev;
        for (int c = 0; c < 5 && grant != 2'b01; c++) @(negedge clk);
        prev = d1_grant;
        n_checks++;
        if (prev !== 2'b01) $display("FAIL alt_start: got %b expected 01", prev);
        else n_pass++;
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          n_checks++;
          if (d1_grant !== {prev[0], prev[1]})
            $display("FAIL alt_toggle: got %b expected %b", d1_grant, {prev[0], prev[1]});
          else n_pass++;
          prev = d1_grant;
        end
      end
    join
    n_checks++;
    if (n_xfer !== 16 || (last_cyc - first_cyc) !== 15)
      $display("FAIL stream_no_gap: got %0d xfers over %0d cycles, expected 16 over 16",
               n_xfer, last_cyc - first_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    s_waitrequest = 1'b1;
    rd_ovr_en = 1'b1;
    rd_ovr = 32'h1234_5678;
    exp_q.push_back('{grant: 2'b01, addr: 32'h40, wr: 1'b0, data: 32'h1234_5678, be: 4'hF});
    exp_q.push_back(mk(1, 32'h44, 1'b1, 32'hA1A1_A1A1));
    fork
      begin host_xfer(0, 1'b1, 1'b0, 32'h40, '0, 30); drive_host(0, 1'b0, 1'b0, '0, '0); end
      begin host_xfer(1, 1'b0, 1'b1, 32'h44, 32'hA1A1_A1A1, 40); drive_host(1, 1'b0, 1'b0, '0, '0); end
      begin
        bit stall_ok = 1'b1;
        for (int c = 0; c < 5 && grant != 2'b01; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (grant !== 2'b01 || h0_waitrequest !== 1'b1 || h1_waitrequest !== 1'b1) stall_ok = 1'b0;
        end
        n_checks++;
        if (!stall_ok) $display("FAIL stall_hold: got grant=%b w0=%b w1=%b, expected 01 1 1",
                                grant, h0_waitrequest, h1_waitrequest);
        else n_pass++;
        @(posedge clk); #1;
        s_waitrequest = 1'b0;
      end
    join
    rd_ovr_en = 1'b0;
  endtask

  task automatic test_rw_error();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (arb_error !== 1'b0) $display("FAIL err_clear_start: got %b expected 0", arb_error);
    else n_pass++;
    exp_q.push_back(mk(0, 32'h80, 1'b1, 32'hCAFE_0001));
    @(posedge clk); #1;
    host_xfer(0, 1'b1, 1'b1, 32'h80, 32'hCAFE_0001, 10);
    drive_host(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (arb_error !== 1'b1) $display("FAIL err_set: got %b expected 1", arb_error);
    else n_pass++;
    exp_q.push_back(mk(1, 32'h90, 1'b1, 32'h0000_0042));
    @(posedge clk); #1;
    host_xfer(1, 1'b0, 1'b1, 32'h90, 32'h0000_0042, 10);
    drive_host(1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (arb_error !== 1'b1) $display("FAIL err_sticky: got %b expected 1", arb_error);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    s_waitrequest = 1'b1;
    drive_host(1, 1'b1, 1'b0, 32'h500, '0);
    for (int c = 0; c < 5 && grant != 2'b10; c++) @(negedge clk);
    n_checks++;
    if ({grant, s_read} !== 3'b10_1) $display("FAIL rm_active: got grant=%b rd=%b, expected 10 1", grant, s_read);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, s_read, s_write, h1_waitrequest, arb_error, d1_grant} !== 8'b00_0_0_1_0_00)
      $display("FAIL rm_abort: got grant=%b rd=%b wr=%b w1=%b err=%b g1=%b, expected 00 0 0 1 0 00",
               grant, s_read, s_write, h1_waitrequest, arb_error, d1_grant);
    else n_pass++;
    drive_host(1, 1'b0, 1'b0, '0, '0);
    s_waitrequest = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 32'h600, 1'b0, '0));
    exp_q.push_back(mk(1, 32'h700, 1'b0, '0));
    fork
      begin host_xfer(0, 1'b1, 1'b0, 32'h600, '0, 10); drive_host(0, 1'b0, 1'b0, '0, '0); end
      begin host_xfer(1, 1'b1, 1'b0, 32'h700, '0, 10); drive_host(1, 1'b0, 1'b0, '0, '0); end
    join
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_stream();
    test_stall();
    test_rw_error();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_host_arbiter.md
DUAL_HOST_ARBITER -- requirements
Module: dual_host_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: Avalon-MM word address width, all ports.
REQ-002 Parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 Parameter MAX_HOLD, default 4, range 1..255: max consecutive transfers for one host while the other waits.
REQ-004 clk_clk  in  1: single clock; all logic on rising edge.
REQ-005 reset_reset_n  in  1: asynchronous, active-low reset.
REQ-006 hN_address / hN_byteenable / hN_writedata  in  ADDR_W / DATA_W/8 / DATA_W: host N (N=0,1) request fields.
REQ-007 hN_read, hN_write  in  1 each: host N request strobes.
REQ-008 hN_readdata  out  DATA_W: read data to host N, valid when hN_read high and hN_waitrequest low.
REQ-009 hN_waitrequest  out  1: stall to host N.
REQ-010 s_address, s_byteenable, s_writedata, s_read, s_write  out  as host fields: shared slave port (DDR3 EMIF Avalon port).
REQ-011 s_readdata  in  DATA_W; s_waitrequest  in  1: slave response.
REQ-012 grant  out  2: one-hot current owner (bit0 host0, bit1 host1), 00 when idle.
REQ-013 arb_error  out  1: sticky protocol-error flag.

Function
REQ-014 States IDLE, GRANT0, GRANT1; state, hold counter and last-served flag are registered.
REQ-015 reqN = hN_read OR hN_write.
REQ-016 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> host not last served; neither -> stay.
REQ-017 Grant takes effect the cycle after the request is first seen (one-cycle arbitration latency from IDLE).
REQ-018 In GRANTn, s_* equal host n fields combinationally; hN_waitrequest = s_waitrequest for owner, 1 for non-owner.
REQ-019 In IDLE, s_read = s_write = 0 and both hN_waitrequest = 1.
REQ-020 Transfer completes when owner req high and s_waitrequest low; hold counter increments (saturating at MAX_HOLD).
REQ-021 Grant never changes while owner req high and s_waitrequest high (no mid-transfer switch).
REQ-022 On completion with other host requesting and counter+1 = MAX_HOLD: switch directly to other GRANT state, counter cleared.
REQ-023 In GRANTn with owner req low: other requesting -> other GRANT state; else -> IDLE; counter cleared.
REQ-024 Last-served flag updates to n on every entry into GRANTn.
REQ-025 hN_readdata = s_readdata for both hosts; only owner's copy qualified.
REQ-026 Owner with read and write both high: forwarded as write only (s_read=0), arb_error set.
REQ-027 arb_error cleared only by reset.
REQ-028 MAX_HOLD=1: strict alternation when both request continuously.

Reset
REQ-029 Reset values: state IDLE, counter 0, last-served = 1 (host0 wins first tie), grant 00, arb_error 0, s_read 0, s_write 0, both hN_waitrequest 1.
REQ-030 Reset mid-transfer aborts immediately; slave strobes drop asynchronously with reset assertion.

Structure
REQ-031 State enumeration and grant encoding constants in shared package hostif_arb_pkg.
REQ-032 Tie-break/next-owner logic in one sub-module rr_arbiter_2 (inputs req[1:0], last; output next owner); rest flat.

Verification
REQ-033 Reset release, h0_write addr 0x100 data 0xDEADBEEF, s_waitrequest low -> grant=01 next cycle, s_write 1 cycle with data 0xDEADBEEF, h0_waitrequest low that cycle.
REQ-034 Both hosts request reads in same cycle from IDLE -> host0 granted first; after its transfer with h1 pending and MAX_HOLD=1, grant=10 next cycle.
REQ-035 MAX_HOLD=4, both hosts stream writes, s_waitrequest low -> pattern 4 transfers host0, 4 host1, no dead cycle at switches, h1_waitrequest high throughout host0 phase.
REQ-036 Owner read held with s_waitrequest high 10 cycles while other requests -> grant unchanged until completion; s_readdata 0x12345678 reaches owner on completion cycle.
REQ-037 Owner asserts read and write together -> s_write=1, s_read=0, arb_error=1 and stays 1 until reset_reset_n low.
REQ-038 reset_reset_n low mid-transfer -> s_read/s_write 0, grant 00 immediately; after release host0 wins tie.
